vital_scan_ctrl: RTL and testbench

VITAL_SCAN_CTRL -- requirements
Module: vital_scan_ctrl

---
 rtl/vital_pkg.sv | 35 +++
 rtl/vital_debounce.sv | 43 ++++
 rtl/vital_scan_ctrl.sv | 174 +++++++++++++++++
 tb/tb_vital_scan_ctrl.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vital_pkg.sv
// Shared types and constants for the vital-sign scan controller.
package vital_pkg;

  // Scan sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_EVAL = 2'd2,
    ST_GAP  = 2'd3
  } state_t;

  // Patient age categories as presented on age_category / age_o
  typedef enum logic [1:0] {
    AGE_INFANT   = 2'b00,
    AGE_CHILD    = 2'b01,
    AGE_ADULT    = 2'b10,
    AGE_PREGNANT = 2'b11
  } age_t;

  localparam int unsigned NCH = 4;

  // Channel indices; also the bit positions in every 4-bit per-channel bus
  localparam logic [1:0] CH_ECG   = 2'd0;
  localparam logic [1:0] CH_TEMP  = 2'd1;
  localparam logic [1:0] CH_SPO2  = 2'd2;
  localparam logic [1:0] CH_SLEEP = 2'd3;

  function automatic logic [NCH-1:0] ch_onehot(input logic [1:0] ch);
    logic [NCH-1:0] v;
    v     = '0;
    v[ch] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/vital_debounce.sv
// Per-channel abnormal-scan debounce: saturating counter plus alarm flop.
module vital_debounce #(
  parameter int unsigned ALARM_CNT = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_upd,   // end-of-scan evaluation strobe
  input  logic i_clr,   // discard history before applying this update
  input  logic i_abn,   // this scan was abnormal (classifier or sensor fault)
  output logic o_alarm
);

  localparam int unsigned CW = $clog2(ALARM_CNT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(ALARM_CNT);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_base;
  logic [CW-1:0] w_next;

  // Next count: optional clear first, then reset on normal or saturating increment
  always_comb begin
    w_base = i_clr ? '0 : r_cnt;
    if (!i_abn) begin
      w_next = '0;
    end else if (w_base == CNT_MAX) begin
      w_next = CNT_MAX;
    end else begin
      w_next = w_base + 1'b1;
    end
  end

  // Counter and alarm update together, so alarm is valid the cycle after the strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      o_alarm <= 1'b0;
    end else if (i_upd) begin
      r_cnt   <= w_next;
      o_alarm <= (w_next == CNT_MAX);
    end
  end

endmodule

// File: rtl/vital_scan_ctrl.sv
// Periodic four-channel vital-sign scanner with per-channel timeout,
// classifier evaluation and debounced alarms.
module vital_scan_ctrl
  import vital_pkg::*;
#(
  parameter int unsigned SCAN_GAP  = 16,
  parameter int unsigned TIMEOUT   = 8,
  parameter int unsigned ALARM_CNT = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_en,
  input  logic [1:0] age_category,
  output logic [3:0] sens_req,
  input  logic [3:0] sens_vld,
  input  logic [7:0] sens_data,
  output logic [7:0] ecg_o,
  output logic [7:0] temp_o,
  output logic [7:0] spo2_o,
  output logic [7:0] sleep_o,
  output logic [1:0] age_o,
  input  logic [3:0] cls_ok,
  output logic [3:0] alarm,
  output logic [3:0] sensor_fault,
  output logic       scan_done,
  output logic       busy
);

  localparam int unsigned WW = (TIMEOUT  > 1) ? $clog2(TIMEOUT)  : 1;
  localparam int unsigned GW = (SCAN_GAP > 1) ? $clog2(SCAN_GAP) : 1;
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(SCAN_GAP - 1);

  state_t        r_state;
  state_t        w_next_state;
  logic [1:0]    r_ch;
  logic [WW-1:0] r_wait;
  logic [GW-1:0] r_gap;
  logic [7:0]    r_snap [NCH];
  logic [3:0]    r_fault;
  logic [1:0]    r_age;
  logic [1:0]    r_prev_age;
  logic          r_done;

  logic          w_vld_sel;
  logic          w_tmo;
  logic          w_adv;
  logic          w_gap_end;
  logic          w_latch;
  logic          w_eval;
  logic          w_age_chg;

  assign w_vld_sel = sens_vld[r_ch];
  assign w_tmo     = (r_wait == WAIT_LAST);
  assign w_adv     = (r_state == ST_REQ) && (w_vld_sel || w_tmo);
  assign w_gap_end = (r_state == ST_GAP) && (r_gap == GAP_LAST);
  assign w_latch   = start_en && ((r_state == ST_IDLE) || w_gap_end);
  assign w_eval    = (r_state == ST_EVAL);
  assign w_age_chg = (r_age != r_prev_age);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; start_en only matters at scan boundaries
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (start_en) w_next_state = ST_REQ;
      ST_REQ:  if (w_adv && (r_ch == CH_SLEEP)) w_next_state = ST_EVAL;
      ST_EVAL: w_next_state = ST_GAP;
      ST_GAP:  if (w_gap_end) w_next_state = start_en ? ST_REQ : ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    sens_req = '0;
    busy     = 1'b0;
    if (r_state == ST_REQ) begin
      sens_req = ch_onehot(r_ch);
    end
    if ((r_state == ST_REQ) || (r_state == ST_EVAL)) begin
      busy = 1'b1;
    end
  end

  // Channel index, per-channel wait counter and age latch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ch   <= '0;
      r_wait <= '0;
      r_age  <= AGE_INFANT;
    end else if (w_latch) begin
      r_ch   <= '0;
      r_wait <= '0;
      r_age  <= age_category;
    end else if (w_adv) begin
      r_ch   <= r_ch + 1'b1;
      r_wait <= '0;
    end else if (r_state == ST_REQ) begin
      r_wait <= r_wait + 1'b1;
    end
  end

  // Inter-scan gap counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gap <= '0;
    end else if (w_eval) begin
      r_gap <= '0;
    end else if (r_state == ST_GAP) begin
      r_gap <= r_gap + 1'b1;
    end
  end

  // Snapshot capture and fault flags; valid takes priority over timeout
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        r_snap[i] <= '0;
      end
      r_fault <= '0;
    end else if (r_state == ST_REQ) begin
      if (w_vld_sel) begin
        r_snap[r_ch]  <= sens_data;
        r_fault[r_ch] <= 1'b0;
      end else if (w_tmo) begin
        r_fault[r_ch] <= 1'b1;
      end
    end
  end

  // Age used by the last evaluated scan, and the end-of-scan pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev_age <= AGE_INFANT;
      r_done     <= 1'b0;
    end else begin
      r_done <= w_eval;
      if (w_eval) begin
        r_prev_age <= r_age;
      end
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_deb
    vital_debounce #(
      .ALARM_CNT (ALARM_CNT)
    ) u_deb (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_upd   (w_eval),
      .i_clr   (w_age_chg),
      .i_abn   (~cls_ok[g] | r_fault[g]),
      .o_alarm (alarm[g])
    );
  end

  assign ecg_o        = r_snap[CH_ECG];
  assign temp_o       = r_snap[CH_TEMP];
  assign spo2_o       = r_snap[CH_SPO2];
  assign sleep_o      = r_snap[CH_SLEEP];
  assign age_o        = r_age;
  assign sensor_fault = r_fault;
  assign scan_done    = r_done;

endmodule

// File: tb/tb_vital_scan_ctrl.sv
// Scoreboard bench for vital_scan_ctrl: driver plans scans, responder plays
// the sensors, monitor checks each completed scan against a behavioural model.
module tb_vital_scan_ctrl;

  localparam int unsigned SCAN_GAP  = 4;
  localparam int unsigned TIMEOUT   = 8;
  localparam int unsigned ALARM_CNT = 3;
  localparam int TMO   = TIMEOUT;
  localparam int ACNT  = ALARM_CNT;
  localparam int NEVER = 255;

  localparam logic [1:0] INFANT = 2'b00;
  localparam logic [1:0] CHILD  = 2'b01;
  localparam logic [1:0] ADULT  = 2'b10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start_en = 1'b0;
  logic [1:0] age_category = 2'b00;
  logic [3:0] sens_vld = 4'h0;
  logic [7:0] sens_data = 8'h00;
  logic [3:0] cls_ok = 4'hF;
  logic [3:0] sens_req;
  logic [7:0] ecg_o, temp_o, spo2_o, sleep_o;
  logic [1:0] age_o;
  logic [3:0] alarm, sensor_fault;
  logic       scan_done, busy;

  vital_scan_ctrl #(
    .SCAN_GAP  (SCAN_GAP),
    .TIMEOUT   (TIMEOUT),
    .ALARM_CNT (ALARM_CNT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_en     (start_en),
    .age_category (age_category),
    .sens_req     (sens_req),
    .sens_vld     (sens_vld),
    .sens_data    (sens_data),
    .ecg_o        (ecg_o),
    .temp_o       (temp_o),
    .spo2_o       (spo2_o),
    .sleep_o      (sleep_o),
    .age_o        (age_o),
    .cls_ok       (cls_ok),
    .alarm        (alarm),
    .sensor_fault (sensor_fault),
    .scan_done    (scan_done),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [3:0][7:0] snap;
    logic [3:0]      fault;
    logic [3:0]      alarm;
    logic [1:0]      age;
    int              busy;
  } exp_t;

  exp_t sb[$];

  // Current scan plan: cycles from request to valid (>= TIMEOUT means never)
  int         cur_lat [4];
  logic [7:0] cur_data [4];
  logic       hold_all = 1'b0;

  // Reference model state
  logic [7:0] m_snap [4];
  int         m_cnt [4];
  logic [1:0] m_prev_age;
  logic [3:0] exp_alarm_now;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  function automatic int req_len(input int c);
    return (cur_lat[c] < TMO) ? cur_lat[c] + 1 : TMO;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 4; c++) begin
      m_snap[c] = 8'h00;
      m_cnt[c]  = 0;
    end
    m_prev_age    = 2'b00;
    exp_alarm_now = 4'h0;
  endtask

  task automatic set_plan(input int l0, l1, l2, l3, input logic [7:0] d0, d1, d2, d3);
    cur_lat[0] = l0; cur_lat[1] = l1; cur_lat[2] = l2; cur_lat[3] = l3;
    cur_data[0] = d0; cur_data[1] = d1; cur_data[2] = d2; cur_data[3] = d3;
  endtask

  task automatic rand_plan(input int max_lat);
    for (int c = 0; c < 4; c++) begin
      cur_lat[c]  = $urandom_range(0, max_lat);
      cur_data[c] = 8'($urandom);
    end
  endtask

  // Apply plan inputs for the next scan and push its expected outcome
  task automatic issue(input logic [1:0] age, input logic [3:0] ok);
    exp_t e;
    age_category = age;
    cls_ok       = ok;
    e.busy = 1;
    for (int c = 0; c < 4; c++) begin
      if (cur_lat[c] < TMO) begin
        m_snap[c]  = cur_data[c];
        e.fault[c] = 1'b0;
      end else begin
        e.fault[c] = 1'b1;
      end
      e.busy += req_len(c);
    end
    if (age != m_prev_age) begin
      for (int c = 0; c < 4; c++) m_cnt[c] = 0;
    end
    m_prev_age = age;
    for (int c = 0; c < 4; c++) begin
      if (ok[c] && !e.fault[c]) m_cnt[c] = 0;
      else if (m_cnt[c] < ACNT) m_cnt[c]++;
      e.alarm[c] = (m_cnt[c] == ACNT);
      e.snap[c]  = m_snap[c];
    end
    e.age = age;
    sb.push_back(e);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    do begin @(negedge clk); n++; end while (!scan_done && n < 400);
    if (!scan_done) check({"timeout_", tag}, 0, 1);
  endtask

  task automatic wait_req(input logic [3:0] v, input string tag);
    int n = 0;
    do begin @(negedge clk); n++; end while (sens_req !== v && n < 400);
    check({"wait_", tag}, sens_req, v);
  endtask

  // Sensor responder: answers requests per plan, adds noise on other valids
  initial begin : responder
    logic [3:0] prev = 4'h0;
    int k = 0;
    int c;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev = 4'h0; k = 0; sens_vld = 4'h0;
        continue;
      end
      check("req_onehot0", 64'($onehot0(sens_req)), 1);
      if (sens_req != prev) begin
        if (prev != 4'h0) begin
          c = prev[0] ? 0 : prev[1] ? 1 : prev[2] ? 2 : 3;
          check($sformatf("req_len_ch%0d", c), k, req_len(c));
        end
        k = 0;
      end
      prev      = sens_req;
      sens_data = 8'($urandom);
      sens_vld  = 4'($urandom);
      if (sens_req != 4'h0) begin
        c = sens_req[0] ? 0 : sens_req[1] ? 1 : sens_req[2] ? 2 : 3;
        sens_vld[c] = 1'b0;
        if (k == cur_lat[c]) begin
          sens_vld[c] = 1'b1;
          sens_data   = cur_data[c];
        end
        if (c == 1 && k == 0) age_category = 2'($urandom);
        k++;
      end
      if (hold_all) sens_vld = 4'hF;
    end
  end

  // Monitor: pops and compares on each scan_done; alarm must hold otherwise
  initial begin : monitor
    int busy_cnt = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        busy_cnt = 0;
        continue;
      end
      if (scan_done) begin
        if (sb.size() == 0) begin
          check("unexpected_scan_done", 1, 0);
        end else begin
          e = sb.pop_front();
          check("snapshots", {sleep_o, spo2_o, temp_o, ecg_o}, e.snap);
          check("sensor_fault", sensor_fault, e.fault);
          check("alarm", alarm, e.alarm);
          check("age_o", age_o, e.age);
          check("busy_cycles", busy_cnt, e.busy);
          exp_alarm_now = e.alarm;
        end
        busy_cnt = 0;
      end else begin
        check("alarm_hold", alarm, exp_alarm_now);
      end
      if (busy) busy_cnt++;
    end
  end

  initial begin : driver
    int n;
    int act;
    logic [5:0] pat;
    logic [1:0] rage;
    model_reset();
    set_plan(2, 2, 2, 2, 8'd75, 8'd98, 8'd95, 8'd8);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("reset_state", {sens_req, ecg_o, temp_o, spo2_o, sleep_o, age_o,
                          alarm, sensor_fault, scan_done, busy}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Normal adult scan
    issue(ADULT, 4'hF);
    start_en = 1'b1;
    wait_done("adult");

    // SpO2 never responds: three faulted scans raise alarm[2]
    cur_lat[2] = NEVER;
    for (int s = 0; s < 3; s++) begin
      issue(ADULT, 4'hF);
      wait_done("spo2_timeout");
    end
    cur_lat[2] = 2;
    issue(ADULT, 4'hF);
    wait_done("spo2_recover");

    // ECG abnormal pattern 0,0,1,0,0,0; valid latency covers the timeout boundary
    pat = 6'b000100;
    for (int s = 0; s < 6; s++) begin
      rand_plan(TMO - 1);
      issue(ADULT, {3'b111, pat[s]});
      wait_done("ecg_pattern");
    end

    // All valids held high: one capture per cycle
    hold_all = 1'b1;
    set_plan(0, 0, 0, 0, 8'd60, 8'd97, 8'd99, 8'd3);
    issue(ADULT, 4'hF);
    wait_done("hold_all");
    hold_all = 1'b0;

    // Age change clears history on temp channel
    set_plan(1, 1, 1, 1, 8'd70, 8'd99, 8'd96, 8'd5);
    issue(ADULT, 4'b1101);
    wait_done("age_a");
    issue(ADULT, 4'b1101);
    wait_done("age_b");
    for (int s = 0; s < 3; s++) begin
      issue(INFANT, 4'b1101);
      wait_done("age_infant");
    end

    // Randomized scans
    rage = ADULT;
    for (int s = 0; s < 24; s++) begin
      rand_plan(TMO + 1);
      if ($urandom_range(0, 3) == 0) rage = 2'($urandom);
      issue(rage, {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
                   ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)});
      wait_done("random");
    end

    // Reset during channel 2 request
    set_plan(3, 3, 3, 3, 8'd11, 8'd22, 8'd33, 8'd44);
    issue(ADULT, 4'h0);
    wait_req(4'b0100, "ch2_before_reset");
    #2 rst_n = 1'b0;
    #1 check("reset_midscan", {sens_req, ecg_o, temp_o, spo2_o, sleep_o, age_o,
                               alarm, sensor_fault, scan_done, busy}, 0);
    sb.delete();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    set_plan(1, 2, NEVER, 0, 8'd66, 8'd77, 8'd88, 8'd99);
    issue(CHILD, 4'hF);
    #2 rst_n = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (sens_req == 4'h0 && n < 50);
    check("restart_ch0", sens_req, 4'b0001);
    wait_done("after_reset");

    // start_en dropped mid-scan: scan completes, then controller stays idle
    set_plan(2, 2, 2, 2, 8'd80, 8'd97, 8'd94, 8'd6);
    issue(ADULT, 4'hF);
    wait_req(4'b0010, "ch1_before_stop");
    start_en = 1'b0;
    wait_done("stop");
    act = 0;
    for (int i = 0; i < 5 * SCAN_GAP; i++) begin
      @(negedge clk);
      if (busy || scan_done || sens_req != 4'h0) act++;
    end
    check("idle_after_stop", act, 0);
    check("scoreboard_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
